// File: rtl/lock_manager_pkg.sv
// Shared constants, command/ack codes and FSM state type for the global hardware lock manager.
package lock_manager_pkg;

  localparam int CMD_TYPE_L   = 0;
  localparam int CMD_TYPE_H   = 7;
  localparam int LOCK_ID_L    = 8;
  localparam int LOCK_ID_H    = 15;
  localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

  typedef enum logic [1:0] {
    LM_IDLE,
    LM_DRAIN,
    LM_RESP
  } LockMgrState_t;

endpackage

// File: rtl/lock_manager.sv
// Global hardware lock arbiter: lock/unlock commands in, single-beat ack responses out.
// Optional LOCK_OWNER_CHECK_EN adds a per-lock owner table (owner-only unlock, idempotent re-lock).
module lock_manager
  import lock_manager_pkg::*;
#(
  parameter int ACC_BITS  = 4,
  parameter int NUM_LOCKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          inStream_tdata,
  input  logic                 inStream_tvalid,
  output logic                 inStream_tready,
  input  logic [ACC_BITS-1:0]  inStream_tid,
  input  logic                 inStream_tlast,
  output logic [63:0]          outStream_tdata,
  output logic                 outStream_tvalid,
  input  logic                 outStream_tready,
  output logic [ACC_BITS-1:0]  outStream_tdest,
  output logic                 outStream_tlast,
  output logic [NUM_LOCKS-1:0] lock_status,
  output logic                 err_bad_cmd
);

  localparam int IDX_W = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
  localparam logic [LOCK_ID_BITS:0] NUM_LOCKS_W = NUM_LOCKS[LOCK_ID_BITS:0];

  LockMgrState_t         state_q, state_d;
  logic [NUM_LOCKS-1:0]  locks_q, locks_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;
  logic [7:0]            ack_q, ack_d;
  logic [7:0]            rid_q, rid_d;
  logic [ACC_BITS-1:0]   dest_q, dest_d;

  logic [7:0]            cmd;
  logic [7:0]            lid;
  logic [IDX_W-1:0]      idx;
  logic [NUM_LOCKS-1:0]  mask;
  logic                  in_range;
  logic                  held;
  logic                  accept;
  logic                  owner_match;
  logic                  owner_we;
  logic                  resp;
  logic [7:0]            ack_c;
  logic                  unused_bits;

  assign cmd         = inStream_tdata[CMD_TYPE_H:CMD_TYPE_L];
  assign lid         = inStream_tdata[LOCK_ID_H:LOCK_ID_L];
  assign idx         = lid[IDX_W-1:0];
  assign in_range    = {1'b0, lid} < NUM_LOCKS_W;
  assign unused_bits = ^inStream_tdata[63:LOCK_ID_H+1];

  always_comb begin
    mask = '0;
    if (in_range) mask[idx] = 1'b1;
  end

  assign held   = |(locks_q & mask);
  assign accept = inStream_tvalid & inStream_tready;

`ifdef LOCK_OWNER_CHECK_EN
  logic [ACC_BITS-1:0] owner_q [NUM_LOCKS];

  assign owner_match = (owner_q[idx] == inStream_tid);

  // NOTE: the owner table has no reset; an entry is only read while its lock bit is set,
  // and that bit is always written together with the entry.
  always_ff @(posedge clk) begin
    if (owner_we) owner_q[idx] <= inStream_tid;
  end
`else
  // Without ownership tracking any accelerator may unlock, and a holder re-locking is rejected.
  assign owner_match = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    locks_d  = locks_q;
    err_d    = err_q;
    pend_d   = pend_q;
    ack_d    = ack_q;
    rid_d    = rid_q;
    dest_d   = dest_q;
    owner_we = 1'b0;
    resp     = 1'b0;
    ack_c    = ACK_REJECT_CODE;

    case (state_q)
      LM_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_LOCK_CODE: begin
              resp = 1'b1;
              if (in_range && !held) begin
                locks_d  = locks_q | mask;
                ack_c    = ACK_OK_CODE;
                owner_we = 1'b1;
              end else if (in_range && owner_match) begin
                ack_c = ACK_OK_CODE;
              end
            end
            CMD_UNLOCK_CODE: begin
`ifdef LOCK_OWNER_CHECK_EN
              if (in_range && held && owner_match) locks_d = locks_q & ~mask;
`else
              if (in_range && held) locks_d = locks_q & ~mask;
`endif
              else err_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase

          if (resp) begin
            ack_d  = ack_c;
            rid_d  = lid;
            dest_d = inStream_tid;
          end

          // Multi-beat commands are decoded on the first beat; the rest is drained.
          if (!inStream_tlast) begin
            state_d = LM_DRAIN;
            pend_d  = resp;
          end else if (resp) begin
            state_d = LM_RESP;
          end
        end
      end
      LM_DRAIN: begin
        if (accept && inStream_tlast) state_d = pend_q ? LM_RESP : LM_IDLE;
      end
      LM_RESP: begin
        if (outStream_tready) state_d = LM_IDLE;
      end
      default: state_d = LM_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same
  // pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LM_IDLE;
      locks_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= '0;
      rid_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      locks_q <= locks_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      rid_q   <= rid_d;
      dest_q  <= dest_d;
    end
  end

  assign inStream_tready  = !rst && (state_q == LM_IDLE || state_q == LM_DRAIN);
  assign outStream_tvalid = (state_q == LM_RESP);
  assign outStream_tlast  = outStream_tvalid;
  assign outStream_tdata  = {48'b0, rid_q, ack_q};
  assign outStream_tdest  = dest_q;
  assign lock_status      = locks_q;
  assign err_bad_cmd      = err_q;

endmodule

// File: tb/tb_lock_manager.sv
// Directed self-checking bench for lock_manager; expectations follow the build's
// LOCK_OWNER_CHECK_EN setting.
module tb_lock_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic [3:0]  in_tid;
  logic        in_tlast;
  logic [63:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic [3:0]  out_tdest;
  logic        out_tlast;
  logic [15:0] lock_status;
  logic        err_bad_cmd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lock_manager #(.ACC_BITS(4), .NUM_LOCKS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .inStream_tdata   (in_tdata),
    .inStream_tvalid  (in_tvalid),
    .inStream_tready  (in_tready),
    .inStream_tid     (in_tid),
    .inStream_tlast   (in_tlast),
    .outStream_tdata  (out_tdata),
    .outStream_tvalid (out_tvalid),
    .outStream_tready (out_tready),
    .outStream_tdest  (out_tdest),
    .outStream_tlast  (out_tlast),
    .lock_status      (lock_status),
    .err_bad_cmd      (err_bad_cmd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [3:0] tid, input logic [63:0] data, input logic last);
    bit ok = 0;
    in_tid    = tid;
    in_tdata  = data;
    in_tlast  = last;
    in_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_tready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic get_resp(input string tag, input logic [63:0] exp_data, input logic [3:0] exp_dest);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_tvalid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_valid"}, ok, 1);
    check({tag, "_data"}, out_tdata, exp_data);
    check({tag, "_dest"}, out_tdest, exp_dest);
    check({tag, "_last"}, out_tlast, 1);
    out_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_tready = 1'b0;
    check({tag, "_done"}, out_tvalid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_tready", in_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_tdata", out_tdata, 0);
    check("rst_tdest", out_tdest, 0);
    check("rst_status", lock_status, 0);
    check("rst_err", err_bad_cmd, 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    in_tdata   = '0;
    in_tvalid  = 1'b0;
    in_tid     = '0;
    in_tlast   = 1'b0;
    out_tready = 1'b0;
    @(negedge clk);
    do_reset();
    check("idle_in_tready", in_tready, 1);

    // 1: grant
    send(4'd3, 64'h0504, 1'b1);
    check("t1_status", lock_status, 16'h0020);
    check("t1_busy_tready", in_tready, 0);
    get_resp("t1", 64'h0501, 4'd3);

    // 2: contended lock rejected
    send(4'd7, 64'h0504, 1'b1);
    get_resp("t2", 64'h0500, 4'd7);
    check("t2_status", lock_status, 16'h0020);

    // 3: unlock (no response) then re-grant to another accelerator
    send(4'd3, 64'h0506, 1'b1);
    check("t3_no_resp", out_tvalid, 0);
    check("t3_status", lock_status, 16'h0000);
    check("t3_idle_tready", in_tready, 1);
    send(4'd7, 64'h0504, 1'b1);
    get_resp("t3b", 64'h0501, 4'd7);
    check("t3b_status", lock_status, 16'h0020);

    // 4: out-of-range lock, bad unlock
    send(4'd2, 64'h1404, 1'b1);
    get_resp("t4", 64'h1400, 4'd2);
    check("t4_status", lock_status, 16'h0020);
    check("t4_err_clear", err_bad_cmd, 0);
    send(4'd2, 64'h0906, 1'b1);
    check("t4_err_set", err_bad_cmd, 1);
    check("t4b_no_resp", out_tvalid, 0);

    // 5: 3-beat lock, downstream stalls 5 cycles
    send(4'd4, 64'h0104, 1'b0);
    check("t5_status_early", lock_status, 16'h0022);
    check("t5_drain_no_resp", out_tvalid, 0);
    send(4'd4, 64'hFFFF, 1'b0);
    send(4'd4, 64'h0606, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_valid", out_tvalid, 1);
      check("t5_stall_data", out_tdata, 64'h0101);
      check("t5_stall_in_tready", in_tready, 0);
      @(negedge clk);
    end
    get_resp("t5", 64'h0101, 4'd4);
    repeat (2) @(negedge clk);
    check("t5_single_resp", out_tvalid, 0);
    check("t5_status_final", lock_status, 16'h0022);

    // Reset while a response is pending drops it and clears all state
    send(4'd3, 64'h0204, 1'b1);
    check("midrst_valid", out_tvalid, 1);
    do_reset();

    // 6: ownership behaviour
    send(4'd3, 64'h0204, 1'b1);
    get_resp("t6_grant", 64'h0201, 4'd3);
    send(4'd3, 64'h0204, 1'b1);
`ifdef LOCK_OWNER_CHECK_EN
    get_resp("t6_relock", 64'h0201, 4'd3);
`else
    get_resp("t6_relock", 64'h0200, 4'd3);
`endif
    send(4'd4, 64'h0206, 1'b1);
`ifdef LOCK_OWNER_CHECK_EN
    check("t6_status", lock_status, 16'h0004);
    check("t6_err", err_bad_cmd, 1);
`else
    check("t6_status", lock_status, 16'h0000);
    check("t6_err", err_bad_cmd, 0);
`endif

    // Unknown command code is flagged without a response
    send(4'd1, 64'h0377, 1'b1);
    check("bad_code_err", err_bad_cmd, 1);
    check("bad_code_no_resp", out_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
